// File: rtl/dvp_frame_tx.sv
// DVP frame transmitter: sensor-style FVAL/LVAL timing with test-pattern or external pixel data.
// All outputs are registered from the next-state decode so they stay aligned with the FSM.
module dvp_frame_tx #(
    parameter int DATA_SIZE = 8,
    parameter int H_ACTIVE  = 1280,
    parameter int V_ACTIVE  = 800,
    parameter int H_BLANK   = 160,
    parameter int V_FRONT   = 16,
    parameter int V_BACK    = 16,
    parameter int V_BLANK   = 64
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iSTART,
    input  logic                 iEND,
    input  logic [1:0]           iMODE,
    input  logic [DATA_SIZE-1:0] iPIX,
    output logic                 oREQ,
    output logic                 oFVAL,
    output logic                 oLVAL,
    output logic [DATA_SIZE-1:0] oDATA,
    output logic [15:0]          oX_Cont,
    output logic [15:0]          oY_Cont,
    output logic [31:0]          oFrame_Cont,
    output logic                 oBUSY
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FRONT  = 3'd1;
    localparam logic [2:0] S_LINE   = 3'd2;
    localparam logic [2:0] S_HBLANK = 3'd3;
    localparam logic [2:0] S_BACK   = 3'd4;
    localparam logic [2:0] S_VBLANK = 3'd5;

    localparam logic [15:0] FRONT_LAST  = 16'(V_FRONT - 1);
    localparam logic [15:0] LINE_LAST   = 16'(H_ACTIVE - 1);
    localparam logic [15:0] HBLANK_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] BACK_LAST   = 16'(V_BACK - 1);
    localparam logic [15:0] VBLANK_LAST = 16'(V_BLANK - 1);
    localparam logic [15:0] ROW_LAST    = 16'(V_ACTIVE - 1);
    localparam logic [15:0] BAR_LAST    = 16'(H_ACTIVE / 8 - 1);

    logic [2:0]  state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [15:0] row, row_nxt;
    logic [15:0] bar_cnt, bar_cnt_nxt;
    logic [2:0]  bar_idx, bar_idx_nxt;
    logic [1:0]  mode, mode_nxt;
    logic        run, run_nxt;

    logic                 fval_nxt;
    logic                 lval_nxt;
    logic                 req_nxt;
    logic                 busy_nxt;
    logic                 frame_rise;
    logic [DATA_SIZE-1:0] data_nxt;
    logic [15:0]          x_nxt;
    logic [15:0]          y_nxt;

    function automatic logic [DATA_SIZE-1:0] pattern(
        input logic [1:0]           m,
        input logic [DATA_SIZE-1:0] x,
        input logic [DATA_SIZE-1:0] y,
        input logic [2:0]           bar,
        input logic [DATA_SIZE-1:0] ext
    );
        logic [DATA_SIZE-1:0] bar_pix;
        bar_pix = '0;
        bar_pix[DATA_SIZE-1 -: 3] = bar;
        case (m)
            2'd0:    return x;
            2'd1:    return y;
            2'd2:    return bar_pix;
            default: return ext;
        endcase
    endfunction

    // The request leads the line by one cycle, so it is high whenever the state after this one is LINE.
    function automatic logic req_ahead(input logic [2:0] st, input logic [15:0] c);
        case (st)
            S_FRONT:  return c == FRONT_LAST;
            S_LINE:   return c != LINE_LAST;
            S_HBLANK: return c == HBLANK_LAST;
            default:  return 1'b0;
        endcase
    endfunction

    // Stage p0: frame/line sequencing for the coming cycle
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 16'd1;
        row_nxt     = row;
        bar_cnt_nxt = bar_cnt;
        bar_idx_nxt = bar_idx;
        mode_nxt    = mode;
        if (iEND) begin
            run_nxt = 1'b0;
        end else if (iSTART && state == S_IDLE) begin
            run_nxt = 1'b1;
        end else begin
            run_nxt = run;
        end

        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if ((run || iSTART) && !iEND) begin
                    state_nxt = S_FRONT;
                    row_nxt   = '0;
                    mode_nxt  = iMODE;
                end
            end
            S_FRONT: begin
                if (cnt == FRONT_LAST) begin
                    state_nxt   = S_LINE;
                    cnt_nxt     = '0;
                    bar_cnt_nxt = '0;
                    bar_idx_nxt = '0;
                end
            end
            S_LINE: begin
                if (bar_cnt == BAR_LAST) begin
                    bar_cnt_nxt = '0;
                    bar_idx_nxt = bar_idx + 3'd1;
                end else begin
                    bar_cnt_nxt = bar_cnt + 16'd1;
                end
                if (cnt == LINE_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = (row < ROW_LAST) ? S_HBLANK : S_BACK;
                end
            end
            S_HBLANK: begin
                if (cnt == HBLANK_LAST) begin
                    state_nxt   = S_LINE;
                    cnt_nxt     = '0;
                    row_nxt     = row + 16'd1;
                    bar_cnt_nxt = '0;
                    bar_idx_nxt = '0;
                end
            end
            S_BACK: begin
                if (cnt == BACK_LAST) begin
                    state_nxt = S_VBLANK;
                    cnt_nxt   = '0;
                end
            end
            S_VBLANK: begin
                if (cnt == VBLANK_LAST) begin
                    cnt_nxt = '0;
                    if (run_nxt) begin
                        state_nxt = S_FRONT;
                        row_nxt   = '0;
                        mode_nxt  = iMODE;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        lval_nxt   = (state_nxt == S_LINE);
        fval_nxt   = (state_nxt != S_IDLE) && (state_nxt != S_VBLANK);
        busy_nxt   = (state_nxt != S_IDLE);
        req_nxt    = req_ahead(state_nxt, cnt_nxt);
        frame_rise = (state_nxt == S_FRONT) && (state != S_FRONT);
        data_nxt   = '0;
        x_nxt      = '0;
        y_nxt      = '0;
        if (lval_nxt) begin
            data_nxt = pattern(mode_nxt, cnt_nxt[DATA_SIZE-1:0], row_nxt[DATA_SIZE-1:0],
                               bar_idx_nxt, iPIX);
            x_nxt    = cnt_nxt;
            y_nxt    = row_nxt;
        end
    end

    // Stage p1: registered control and outputs
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= S_IDLE;
            cnt         <= '0;
            run         <= 1'b0;
            oFVAL       <= 1'b0;
            oLVAL       <= 1'b0;
            oREQ        <= 1'b0;
            oBUSY       <= 1'b0;
            oDATA       <= '0;
            oX_Cont     <= '0;
            oY_Cont     <= '0;
            oFrame_Cont <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            run     <= run_nxt;
            oFVAL   <= fval_nxt;
            oLVAL   <= lval_nxt;
            oREQ    <= req_nxt;
            oBUSY   <= busy_nxt;
            oDATA   <= data_nxt;
            oX_Cont <= x_nxt;
            oY_Cont <= y_nxt;
            if (frame_rise) begin
                oFrame_Cont <= oFrame_Cont + 32'd1;
            end
        end
    end

    // Row, bar and mode are always re-initialised on frame or line entry before use.
    always_ff @(posedge iCLK) begin
        row     <= row_nxt;
        bar_cnt <= bar_cnt_nxt;
        bar_idx <= bar_idx_nxt;
        mode    <= mode_nxt;
    end

endmodule

// File: tb/tb_dvp_frame_tx.sv
// Scoreboard bench for dvp_frame_tx: stimulus pushes expected frames/pixels, a monitor pops and compares.
module tb_dvp_frame_tx;

    localparam int DS  = 8;
    localparam int H   = 16;
    localparam int V   = 4;
    localparam int HB  = 4;
    localparam int VF  = 3;
    localparam int VBK = 2;
    localparam int VBL = 5;
    localparam int P        = VF + V * H + (V - 1) * HB + VBK + VBL;
    localparam int FVAL_LEN = P - VBL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [DS-1:0] pix = '0;
    logic          req, fval, lval, busy;
    logic [DS-1:0] data;
    logic [15:0]   x_cont, y_cont;
    logic [31:0]   frame_cnt;

    dvp_frame_tx #(
        .DATA_SIZE(DS), .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB),
        .V_FRONT(VF), .V_BACK(VBK), .V_BLANK(VBL)
    ) dut (
        .iCLK(clk), .iRST(rst), .iSTART(start), .iEND(stop), .iMODE(mode), .iPIX(pix),
        .oREQ(req), .oFVAL(fval), .oLVAL(lval), .oDATA(data), .oX_Cont(x_cont),
        .oY_Cont(y_cont), .oFrame_Cont(frame_cnt), .oBUSY(busy)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_at_edge = 1'b0;
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    typedef struct { int cyc; int x; int y; int data; } pix_t;
    typedef struct { int rise; int count; } frm_t;
    pix_t pix_q[$];
    frm_t frm_q[$];

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // External pixel source: while requested, supply 0xA0 + number of earlier requests.
    int req_seen = 0;
    initial begin
        forever begin
            @(negedge clk);
            pix = req ? 8'(8'hA0 + req_seen) : 8'($urandom);
            if (req) req_seen++;
        end
    end

    // Monitor
    int   cur_rise = 0;
    bit   active = 1'b0;
    logic prev_fval = 1'b0;
    logic prev_req = 1'b0;
    int   req_in_frame = 0;
    frm_t fe;
    pix_t pe;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_at_edge) begin
                chk("reset_outputs_zero",
                    longint'(fval | lval | req | busy | (|data) | (|x_cont) | (|y_cont) | (|frame_cnt)), 0);
                active = 1'b0;
                req_in_frame = 0;
            end else begin
                if (fval && !prev_fval) begin
                    if (frm_q.size() == 0) begin
                        chk("unexpected_frame_rise", longint'(cyc), -1);
                    end else begin
                        fe = frm_q.pop_front();
                        chk("frame_rise_cycle", longint'(cyc), longint'(fe.rise));
                        chk("frame_count", longint'(frame_cnt), longint'(fe.count));
                    end
                    active = 1'b1;
                    cur_rise = cyc;
                    req_in_frame = 0;
                end
                chk("fval", longint'(fval), longint'(active && cyc < cur_rise + FVAL_LEN));
                chk("busy", longint'(busy), longint'(active && cyc < cur_rise + P));
                if (active && cyc == cur_rise + FVAL_LEN)
                    chk("req_per_frame", longint'(req_in_frame), longint'(H * V));
                chk("req_leads_lval", longint'(lval), longint'(prev_req));
                if (lval) begin
                    if (pix_q.size() == 0) begin
                        chk("unexpected_pixel", longint'(cyc), -1);
                    end else begin
                        pe = pix_q.pop_front();
                        chk("pixel_cycle", longint'(cyc), longint'(pe.cyc));
                        chk("pixel_x", longint'(x_cont), longint'(pe.x));
                        chk("pixel_y", longint'(y_cont), longint'(pe.y));
                        chk("pixel_data", longint'(data), longint'(pe.data));
                    end
                end else begin
                    chk("data_idle_zero", longint'(data), 0);
                end
                if (req) req_in_frame++;
            end
            prev_fval = fval;
            prev_req  = req;
        end
    end

    // Reference model and stimulus
    int exp_frames = 0;
    int ext_next = 0;
    int modes[8];

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frames(input int rise0, input int nfr);
        int rise, c, d;
        for (int f = 0; f < nfr; f++) begin
            rise = rise0 + f * P;
            exp_frames++;
            frm_q.push_back('{rise, exp_frames});
            for (int y = 0; y < V; y++) begin
                for (int x = 0; x < H; x++) begin
                    c = rise + VF + y * (H + HB) + x;
                    case (modes[f])
                        0:       d = x % 256;
                        1:       d = y % 256;
                        2:       d = (x / (H / 8)) << (DS - 3);
                        default: d = (8'hA0 + ext_next) % 256;
                    endcase
                    ext_next++;
                    pix_q.push_back('{c, x, y, d});
                end
            end
        end
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_pixels_left"}, longint'(pix_q.size()), 0);
        chk({tag, "_frames_left"}, longint'(frm_q.size()), 0);
        chk({tag, "_frame_cnt"}, longint'(frame_cnt), longint'(exp_frames));
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_fval"}, longint'(fval), 0);
        pix_q.delete();
        frm_q.delete();
    endtask

    // Start a run of nfr frames; iEND pulsed at end_off in the last frame, optional stray iSTART.
    task automatic run_frames(input string tag, input int nfr, input int end_off, input int stray_off);
        int rise0, f, off;
        repeat ($urandom_range(1, 8)) next();
        ext_next = req_seen;
        mode  = 2'(modes[0]);
        start = 1'b1;
        rise0 = cyc + 1;
        push_frames(rise0, nfr);
        next();
        start = 1'b0;
        for (int t = 0; t < nfr * P; t++) begin
            f   = t / P;
            off = t % P;
            if (off == 20) mode = (f < nfr - 1) ? 2'(modes[f + 1]) : 2'($urandom);
            stop  = (f == nfr - 1) && (off == end_off);
            start = (f == nfr - 1) && (off == stray_off);
            next();
        end
        stop  = 1'b0;
        start = 1'b0;
        repeat (6) next();
        idle_checks(tag);
    endtask

    initial begin
        int rise0, rc, nfr;
        repeat (4) next();
        chk("reset_fval", longint'(fval), 0);
        chk("reset_frame_cnt", longint'(frame_cnt), 0);
        chk("reset_req", longint'(req), 0);
        rst = 1'b0;
        next();

        // single frame, X ramp, iEND the cycle after iSTART
        modes[0] = 0;
        run_frames("single", 1, 0, -1);

        // continuous colour bars, three frames
        for (int i = 0; i < 3; i++) modes[i] = 2;
        run_frames("bars", 3, $urandom_range(0, P - 2), -1);

        // external pixels, two frames
        modes[0] = 3; modes[1] = 3;
        run_frames("external", 2, $urandom_range(0, P - 2), -1);

        // iSTART and iEND together while idle: nothing happens
        repeat (3) next();
        start = 1'b1; stop = 1'b1;
        next();
        start = 1'b0; stop = 1'b0;
        repeat (100) next();
        idle_checks("start_end_same");

        // iEND during line 2, stray iSTART late in the frame
        modes[0] = 1;
        run_frames("mid_end", 1, VF + 2 * (H + HB) + $urandom_range(0, H - 1), $urandom_range(60, P - 2));

        // random runs with per-frame mode changes
        for (int i = 0; i < 3; i++) begin
            nfr = $urandom_range(1, 3);
            for (int k = 0; k < nfr; k++) modes[k] = $urandom_range(0, 3);
            run_frames("random", nfr, $urandom_range(0, P - 2), $urandom_range(0, P - 2));
        end

        // reset mid-line
        modes[0] = $urandom_range(0, 2);
        modes[1] = modes[0];
        repeat (3) next();
        ext_next = req_seen;
        mode  = 2'(modes[0]);
        start = 1'b1;
        rise0 = cyc + 1;
        push_frames(rise0, 2);
        next();
        start = 1'b0;
        while (cyc < rise0 + VF + $urandom_range(0, V - 1) * (H + HB) + $urandom_range(0, H - 1)) next();
        rst = 1'b1;
        rc  = cyc;
        while (pix_q.size() > 0 && pix_q[$].cyc > rc) void'(pix_q.pop_back());
        while (frm_q.size() > 0 && frm_q[$].rise > rc) void'(frm_q.pop_back());
        exp_frames = 0;
        next();
        rst = 1'b0;
        chk("midreset_fval", longint'(fval), 0);
        chk("midreset_lval", longint'(lval), 0);
        chk("midreset_busy", longint'(busy), 0);
        chk("midreset_frame_cnt", longint'(frame_cnt), 0);
        repeat (100) next();
        idle_checks("after_reset");

        // recovery after reset
        modes[0] = $urandom_range(0, 3);
        run_frames("recover", 1, $urandom_range(0, P - 2), -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
